// File: rtl/scan_loader.sv
// Scan-chain master: shifts a byte stream MSB-first into the selected pattern buffer
// and returns the displaced old contents as a byte stream.
`timescale 1ns/1ps
module scan_loader #(
  parameter int unsigned buffer_size  = 22,
  parameter int unsigned buffer_width = 8,
  parameter int unsigned addr_width   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addr_width-1:0]   buf_addr,
  output logic                    busy,
  output logic                    done,
  input  logic [buffer_width-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [buffer_width-1:0] dout,
  output logic                    dout_valid,
  output logic                    ssel,
  output logic [addr_width-1:0]   saddr,
  output logic                    sin,
  input  logic                    sout
);

  localparam int unsigned ByteCntW = $clog2(buffer_size + 1);
  localparam int unsigned BitCntW  = $clog2(buffer_width + 1);

  typedef enum logic [1:0] {StIdle, StWaitByte, StShift, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ByteCntW-1:0]     byte_cnt_q;
  logic [BitCntW-1:0]      bit_cnt_q;
  logic [buffer_width-1:0] shift_q;
  logic [buffer_width-2:0] cap_q;
  logic [buffer_width-1:0] cap_next;
  logic [buffer_width-1:0] dout_q;
  logic                    dout_valid_q;
  logic [addr_width-1:0]   saddr_q;
  logic                    last_bit;
  logic                    last_byte;

  // First bit out of the chain lands in the MSB of the returned byte.
  assign cap_next  = {cap_q, sout};
  assign last_bit  = (bit_cnt_q == BitCntW'(buffer_width - 1));
  assign last_byte = (byte_cnt_q == ByteCntW'(buffer_size - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StWaitByte;
      StWaitByte: if (din_valid) state_d = StShift;
      StShift:    if (last_bit) state_d = last_byte ? StDone : StWaitByte;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      cap_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      saddr_q      <= '0;
    end else begin
      dout_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            saddr_q    <= buf_addr;
            byte_cnt_q <= '0;
          end
        end
        StWaitByte: begin
          if (din_valid) begin
            shift_q   <= din;
            bit_cnt_q <= '0;
          end
        end
        StShift: begin
          shift_q   <= shift_q << 1;
          cap_q     <= cap_next[buffer_width-2:0];
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (last_bit) begin
            dout_q       <= cap_next;
            dout_valid_q <= 1'b1;
            byte_cnt_q   <= byte_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == StWaitByte) || (state_q == StShift);
    done       = (state_q == StDone);
    din_ready  = (state_q == StWaitByte);
    ssel       = (state_q == StShift);
    sin        = (state_q == StShift) & shift_q[buffer_width-1];
    dout       = dout_q;
    dout_valid = dout_valid_q;
    saddr      = saddr_q;
  end

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: behavioural buffer-bank model plus a readback scoreboard.
`timescale 1ns/1ps
module tb_scan_loader;

  localparam int unsigned BS = 22;
  localparam int unsigned BW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = BS * BW;

  logic          clk = 1'b0;
  logic          rst, start, din_valid, sout;
  logic [AW-1:0] buf_addr;
  logic [BW-1:0] din;
  logic          busy, done, din_ready, dout_valid, ssel, sin;
  logic [BW-1:0] dout;
  logic [AW-1:0] saddr;

  scan_loader #(
    .buffer_size (BS),
    .buffer_width(BW),
    .addr_width  (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .buf_addr  (buf_addr),
    .busy      (busy),
    .done      (done),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .ssel      (ssel),
    .saddr     (saddr),
    .sin       (sin),
    .sout      (sout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int ssel_cnt = 0;
  int dv_cnt = 0;
  int done_cnt = 0;

  logic [BW-1:0] img [8][BS];
  logic [BW-1:0] wr [BS];
  logic [CW-1:0] chain [8];
  logic          model_init;
  logic [BW-1:0] exp_q [$];

  // Buffer bank model: sin enters at the head, sout is the tail bit.
  assign sout = chain[saddr][CW-1];
  always @(posedge clk) begin
    if (model_init) begin
      for (int b = 0; b < 8; b++)
        for (int k = 0; k < BS; k++) chain[b][(BS-1-k)*BW +: BW] <= img[b][k];
    end else if (ssel === 1'b1) begin
      chain[saddr] <= {chain[saddr][CW-2:0], sin};
    end
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ssel === 1'b1) ssel_cnt++;
      if (done === 1'b1) done_cnt++;
      if (dout_valid === 1'b1) begin
        dv_cnt++;
        if (exp_q.size() == 0) check("dout_unexpected", CW'(dout_valid), CW'(0));
        else check("dout", CW'(dout), CW'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [CW-1:0] pack_wr();
    logic [CW-1:0] p;
    for (int k = 0; k < BS; k++) p[(BS-1-k)*BW +: BW] = wr[k];
    return p;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (din_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // stall_at: byte after which din_valid drops for 5 cycles; noise: stray start/din_valid;
  // abort_at: byte during whose bit 4 reset is asserted.
  task automatic run_load(input int addr, input int stall_at, input bit noise, input int abort_at);
    int  t0;
    bit  ok;
    bit  got_done;
    ssel_cnt = 0;
    dv_cnt   = 0;
    done_cnt = 0;
    for (int k = 0; k < BS; k++) exp_q.push_back(img[addr][k]);
    start    = 1'b1;
    buf_addr = AW'(addr);
    @(posedge clk); #1;
    start    = 1'b0;
    buf_addr = ~AW'(addr);
    t0 = cyc;
    for (int k = 0; k < BS; k++) begin
      din       = wr[k];
      din_valid = 1'b1;
      wait_ready(ok);
      if (!ok) begin
        check("din_ready_timeout", CW'(din_ready), CW'(1));
        din_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (k == abort_at) begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("abort_ssel", CW'(ssel), CW'(0));
        check("abort_busy", CW'(busy), CW'(0));
        repeat (20) @(negedge clk);
        check("abort_no_done", CW'(done_cnt), CW'(0));
        check("abort_dv_cnt", CW'(dv_cnt), CW'(abort_at));
        exp_q.delete();
        return;
      end
      if (noise && k == 5) begin
        @(posedge clk); #1;
        start    = 1'b1;
        buf_addr = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("noise_saddr", CW'(saddr), CW'(addr));
        check("noise_busy", CW'(busy), CW'(1));
      end
      if (k == stall_at) begin
        din_valid = 1'b0;
        wait_ready(ok);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_ssel", CW'(ssel), CW'(0));
          check("stall_ready", CW'(din_ready), CW'(1));
        end
        @(posedge clk); #1;
      end
    end
    din_valid = 1'b0;
    got_done  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
    end
    if (!got_done) begin
      check("done_timeout", CW'(done), CW'(1));
      return;
    end
    check("done_latency", CW'(cyc - t0), CW'(BS * 9 + (stall_at >= 0 ? 5 : 0)));
    check("busy_in_done", CW'(busy), CW'(0));
    if (noise) begin
      start    = 1'b1;
      buf_addr = 3'd5;
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", CW'(done), CW'(0));
    check("idle_busy", CW'(busy), CW'(0));
    check("done_cnt", CW'(done_cnt), CW'(1));
    check("dv_cnt", CW'(dv_cnt), CW'(BS));
    check("ssel_cnt", CW'(ssel_cnt), CW'(BS * BW));
    check("sb_empty", CW'(exp_q.size()), CW'(0));
    check("saddr_hold", CW'(saddr), CW'(addr));
    check("chain_image", chain[addr], pack_wr());
    for (int k = 0; k < BS; k++) img[addr][k] = wr[k];
  endtask

  initial begin
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < BS; k++) img[b][k] = BW'((b << 5) ^ k ^ 8'h5A);
    model_init = 1'b1;
    rst        = 1'b1;
    start      = 1'b1;
    din_valid  = 1'b1;
    din        = 8'h33;
    buf_addr   = 3'd7;
    repeat (2) @(posedge clk);
    #1 model_init = 1'b0;
    @(negedge clk);
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_done", CW'(done), CW'(0));
    check("rst_din_ready", CW'(din_ready), CW'(0));
    check("rst_dout_valid", CW'(dout_valid), CW'(0));
    check("rst_ssel", CW'(ssel), CW'(0));
    check("rst_sin", CW'(sin), CW'(0));
    check("rst_dout", CW'(dout), CW'(0));
    check("rst_saddr", CW'(saddr), CW'(0));
    rst      = 1'b0;
    start    = 1'b0;
    ssel_cnt = 0;
    repeat (3) @(negedge clk);
    check("idle_din_ready", CW'(din_ready), CW'(0));
    check("idle_busy0", CW'(busy), CW'(0));
    check("idle_no_ssel", CW'(ssel_cnt), CW'(0));
    din_valid = 1'b0;

    for (int k = 0; k < BS; k++) wr[k] = BW'(k);
    run_load(2, -1, 1'b0, -1);
    for (int k = 0; k < BS; k++) wr[k] = 8'hFF;
    run_load(2, -1, 1'b0, -1);
    for (int k = 0; k < BS; k++) wr[k] = BW'(k * 7 + 3);
    run_load(4, 3, 1'b0, -1);
    for (int k = 0; k < BS; k++) wr[k] = ~BW'(k);
    run_load(6, -1, 1'b1, -1);
    for (int k = 0; k < BS; k++) wr[k] = BW'(8'hC3 ^ k);
    run_load(1, -1, 1'b0, 10);
    for (int k = 0; k < BS; k++) wr[k] = BW'(8'h40 + k);
    run_load(3, -1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
